reg_op_arbiter: RTL

Sequencer and arbiter that shares one general-purpose data register (clear/load/inc/dec/shift control strobes) between four requesters. Each requester posts an opcode, an operand and a repeat count. The block grants one requester at a time, drives the register's control strobes for the required number of cycles, then returns a one-cycle completion pulse. It sits between the control units and the register instance in the datapath.

---
 rtl/reg_op_arbiter_if.sv | 35 +++
 rtl/reg_op_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/reg_op_arbiter_if.sv
// Bundle between the four requesters, the arbiter and the shared data register.
// The master side is the requesters and the register; the slave side is the arbiter.
interface reg_op_arbiter_if #(
   parameter int DATA_WIDTH = 16
);
   logic [3:0]              req;
   logic [11:0]             op;
   logic [4*DATA_WIDTH-1:0] arg;
   logic [15:0]             cnt;
   logic [3:0]              ser;
   logic [DATA_WIDTH-1:0]   reg_q;

   logic                    cl;
   logic                    ld;
   logic                    inc;
   logic                    dec;
   logic                    sr;
   logic                    ir;
   logic                    sl;
   logic                    il;
   logic [DATA_WIDTH-1:0]   reg_in;
   logic [3:0]              gnt;
   logic [3:0]              done;
   logic                    busy;

   modport master (
      output req, op, arg, cnt, ser, reg_q,
      input  cl, ld, inc, dec, sr, ir, sl, il, reg_in, gnt, done, busy
   );

   modport slave (
      input  req, op, arg, cnt, ser, reg_q,
      output cl, ld, inc, dec, sr, ir, sl, il, reg_in, gnt, done, busy
   );
endinterface

// File: rtl/reg_op_arbiter.sv
// Shares one data register between four requesters and sequences its control strobes.
// Define ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module reg_op_arbiter #(
   parameter int DATA_WIDTH = 16
) (
   input logic             clk,
   input logic             rst,
   reg_op_arbiter_if.slave bus
);
   localparam int NUM_REQ = 4;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
   typedef enum logic [2:0] {
      OP_CLR, OP_LOAD, OP_INC, OP_DEC, OP_SHR, OP_SHL, OP_ROR, OP_ROL
   } opcode_t;

   state_t                state;
   state_t                state_next;
   logic [1:0]            win;
   logic [1:0]            pick;
   logic                  any_req;
   opcode_t               lat_op;
   logic [DATA_WIDTH-1:0] lat_arg;
   logic                  lat_ser;
   logic [3:0]            remaining;
   logic [2:0]            pick_op;
   logic [3:0]            pick_cnt;
   logic [3:0]            pick_count;

   assign any_req = |bus.req;

`ifdef ROUND_ROBIN_EN
   logic [1:0] rr_ptr;

   // Scan downward so the candidate closest to the pointer is the last (winning) assignment.
   always_comb begin
      pick = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (bus.req[rr_ptr + 2'(k)]) pick = rr_ptr + 2'(k);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (state == IDLE && any_req) begin
         rr_ptr <= pick + 2'd1;
      end
   end
`else
   always_comb begin
      pick = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (bus.req[k]) pick = 2'(k);
      end
   end
`endif

   // CLR and LOAD run once; every other opcode treats a zero count as one.
   always_comb begin
      pick_op  = bus.op[3*pick +: 3];
      pick_cnt = bus.cnt[4*pick +: 4];
      if (pick_op == OP_CLR || pick_op == OP_LOAD) begin
         pick_count = 4'd1;
      end else if (pick_cnt == 4'd0) begin
         pick_count = 4'd1;
      end else begin
         pick_count = pick_cnt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win       <= '0;
         lat_op    <= OP_CLR;
         lat_arg   <= '0;
         lat_ser   <= 1'b0;
         remaining <= '0;
      end else if (state == IDLE && any_req) begin
         win       <= pick;
         lat_op    <= opcode_t'(pick_op);
         lat_arg   <= bus.arg[DATA_WIDTH*pick +: DATA_WIDTH];
         lat_ser   <= bus.ser[pick];
         remaining <= pick_count;
      end else if (state == EXEC) begin
         remaining <= remaining - 4'd1;
      end
   end

   // Rotates take their fill bit straight from reg_q so every repeat sees the updated value.
   always_comb begin
      state_next = state;
      bus.cl     = 1'b0;
      bus.ld     = 1'b0;
      bus.inc    = 1'b0;
      bus.dec    = 1'b0;
      bus.sr     = 1'b0;
      bus.ir     = 1'b0;
      bus.sl     = 1'b0;
      bus.il     = 1'b0;
      bus.reg_in = '0;
      bus.gnt    = '0;
      bus.done   = '0;
      bus.busy   = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) state_next = EXEC;
         end
         EXEC: begin
            bus.busy = 1'b1;
            bus.gnt  = 4'b0001 << win;
            if (remaining == 4'd1) state_next = DONE;
            case (lat_op)
               OP_CLR:  bus.cl = 1'b1;
               OP_LOAD: begin
                  bus.ld     = 1'b1;
                  bus.reg_in = lat_arg;
               end
               OP_INC:  bus.inc = 1'b1;
               OP_DEC:  bus.dec = 1'b1;
               OP_SHR:  begin
                  bus.sr = 1'b1;
                  bus.ir = lat_ser;
               end
               OP_SHL:  begin
                  bus.sl = 1'b1;
                  bus.il = lat_ser;
               end
               OP_ROR:  begin
                  bus.sr = 1'b1;
                  bus.ir = bus.reg_q[0];
               end
               OP_ROL:  begin
                  bus.sl = 1'b1;
                  bus.il = bus.reg_q[DATA_WIDTH-1];
               end
            endcase
         end
         DONE: begin
            bus.busy   = 1'b1;
            bus.gnt    = 4'b0001 << win;
            bus.done   = 4'b0001 << win;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end
endmodule
